// File: rtl/note_sequencer_if.sv
// note_sequencer_if
//   Bundles the sequencer's control inputs, song ROM bus and note output.
//   master : the sequencer (drives rom_addr and the note/status outputs)
//   slave  : the environment (drives tick/start/pause and the ROM data)
//   Signals: tick, start, pause, rom_addr[ADDR_W], rom_data[30],
//            note_trigger, note_data[18], playing, song_done, note_index[ADDR_W]
interface note_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              tick;
    logic              start;
    logic              pause;
    logic [ADDR_W-1:0] rom_addr;
    logic [29:0]       rom_data;
    logic              note_trigger;
    logic [17:0]       note_data;
    logic              playing;
    logic              song_done;
    logic [ADDR_W-1:0] note_index;

    modport master (
        input  tick, start, pause, rom_data,
        output rom_addr, note_trigger, note_data, playing, song_done, note_index
    );

    modport slave (
        output tick, start, pause, rom_data,
        input  rom_addr, note_trigger, note_data, playing, song_done, note_index
    );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer
//   Walks a synchronous song ROM and issues one note_trigger/note_data pulse
//   per note, spacing entries by their gap field counted in 10 ms ticks.
//   Ports:
//     clk, reset (async, active high)
//     bus.master : tick/start/pause in, rom_addr out / rom_data in,
//                  note_trigger, note_data {key,duration}, playing,
//                  song_done, note_index out
//   ROM entry: {key[29:24], duration[23:12], gap[11:0]}
module note_sequencer #(
    parameter int         ADDR_W   = 8,
    parameter logic [5:0] END_KEY  = 6'd63,
    parameter logic [5:0] REST_KEY = 6'd0
) (
    input  logic               clk,
    input  logic               reset,
    note_sequencer_if.master   bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, GAP, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, idx_q;
    logic [11:0]       gap_q, cnt_q;
    logic [17:0]       data_q;
    logic              trig_q, done_q, play_q;

    logic [5:0]        key;
    logic [11:0]       dur, gap;
    logic              tick_en;

    // Control strobes from the next-state logic to the datapath
    logic restart, latch, trig, finish, adv, addr_inc, cnt_clr, cnt_inc;

    assign key     = bus.rom_data[29:24];
    assign dur     = bus.rom_data[23:12];
    assign gap     = bus.rom_data[11:0];
    assign tick_en = bus.tick && !bus.pause;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        restart  = 1'b0;
        latch    = 1'b0;
        trig     = 1'b0;
        finish   = 1'b0;
        adv      = 1'b0;
        addr_inc = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    restart = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = LATCH;
            LATCH: begin
                latch = 1'b1;
                if (key == END_KEY) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end else begin
                    // Trigger is registered here so it is high during ISSUE
                    trig    = (key != REST_KEY);
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (gap_q == '0) begin
                    adv = 1'b1;
                end else begin
                    cnt_clr = 1'b1;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (tick_en) begin
                    if (cnt_q + 12'd1 == gap_q) adv     = 1'b1;
                    else                        cnt_inc = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Advance: the song ends at the last address rather than wrapping
        if (adv) begin
            if (addr_q == '1) begin
                finish  = 1'b1;
                state_n = DONE;
            end else begin
                addr_inc = 1'b1;
                state_n  = FETCH;
            end
        end

        // start mid-song restarts from entry 0 and overrides everything else
        if (bus.start && state != IDLE && state != DONE) begin
            restart  = 1'b1;
            latch    = 1'b0;
            trig     = 1'b0;
            finish   = 1'b0;
            addr_inc = 1'b0;
            cnt_inc  = 1'b0;
            cnt_clr  = 1'b1;
            state_n  = FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            idx_q  <= '0;
            gap_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            trig_q <= 1'b0;
            done_q <= 1'b0;
            play_q <= 1'b0;
        end else begin
            trig_q <= trig;
            done_q <= finish;
            if (restart) begin
                addr_q <= '0;
                play_q <= 1'b1;
            end else if (addr_inc) begin
                addr_q <= addr_q + 1'b1;
            end
            if (finish) play_q <= 1'b0;
            if (latch) begin
                idx_q <= addr_q;
                gap_q <= gap;
            end
            // note_data only changes on a real trigger, rests leave it alone
            if (trig) data_q <= {key, dur};
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 12'd1;
        end
    end

    assign bus.rom_addr     = addr_q;
    assign bus.note_trigger = trig_q;
    assign bus.note_data    = data_q;
    assign bus.playing      = play_q;
    assign bus.song_done    = done_q;
    assign bus.note_index   = idx_q;
endmodule
